fp_norm_round: RTL and testbench

Three-stage pipelined normalize-and-round unit for IEEE-754 binary64 results in the FPU. It consumes an unnormalized 64-bit magnitude, a signed biased exponent and a sign produced by the add/mul/convert datapaths. Internally it locates the leading one, normalizes or denormalizes, and rounds per the RISC-V rounding mode. It emits the packed double plus accrued exception flags over a valid/ready handshake.

---
 rtl/fp_norm_round.sv | 197 +++++++++++++++++++
 tb/tb_fp_norm_round.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// Three-stage binary64 normalize-and-round unit: leading-one normalize (S1),
// denormalize and fraction extraction (S2), RISC-V rounding and packing (S3).
module fp_norm_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [12:0] in_exp,
    input  logic [63:0] in_mant,
    input  logic        in_sticky,
    input  logic [2:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [4:0]  out_flags
);

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // Handshake: an input transfers on a rising edge when in_valid & in_ready,
    // an output when out_valid & out_ready. The whole pipe moves as one unit
    // whenever the output register is empty or being drained.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ---------------- S1: leading-one detect and normalize ----------------
    logic [5:0]         lead_idx;
    logic [5:0]         lz;
    logic signed [13:0] exp_x;
    logic signed [13:0] e1;
    logic [63:0]        norm_mant;
    logic [2:0]         rm_c;

    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < 64; i++) begin
            if (in_mant[i]) lead_idx = 6'(i);
        end
    end

    assign lz        = 6'd63 - lead_idx;
    assign exp_x     = 14'(signed'(in_exp));
    assign e1        = exp_x - signed'({8'b0, lz});
    assign norm_mant = in_mant << lz;
    assign rm_c      = (in_rm > RM_RMM) ? RM_RNE : in_rm;

    logic               s1_valid;
    logic               s1_sign;
    logic [2:0]         s1_rm;
    logic               s1_sticky;
    logic               s1_zero;
    logic signed [13:0] s1_exp;
    logic [63:0]        s1_mant;

    // ---------------- S2: denormalize and extract fraction ----------------
    logic               s2_normal;
    logic signed [13:0] den_amt;
    logic [6:0]         den_sh;
    logic [128:0]       den_full;
    logic [63:0]        m2;
    logic               stk_pre;
    logic [12:0]        exp2;

    // A 65-bit shift pushes the whole 64-bit mantissa into the sticky field.
    assign s2_normal = (s1_exp >= 14'sd1);
    assign den_amt   = 14'sd1 - s1_exp;
    assign den_sh    = (den_amt > 14'sd65) ? 7'd65 : den_amt[6:0];
    assign den_full  = {s1_mant, 65'b0} >> den_sh;

    always_comb begin
        m2      = s1_mant;
        stk_pre = s1_sticky;
        exp2    = s1_exp[12:0];
        if (!s2_normal) begin
            m2      = den_full[128:65];
            stk_pre = s1_sticky | (|den_full[64:0]);
            exp2    = 13'd0;
        end
    end

    logic        s2_valid;
    logic        s2_sign;
    logic [2:0]  s2_rm;
    logic        s2_zero;
    logic        s2_zsticky;
    logic        s2_tiny;
    logic [12:0] s2_exp;
    logic [52:0] s2_sig;
    logic        s2_guard;
    logic        s2_stk;

    // ---------------- S3: round, detect overflow, pack ----------------
    logic        inc;
    logic        nx;
    logic [53:0] sum;
    logic        carry;
    logic [12:0] exp_r;
    logic [51:0] frac_r;
    logic        ovf;
    logic        to_inf;
    logic [63:0] res_c;
    logic [4:0]  flags_c;

    assign nx = s2_guard | s2_stk;

    always_comb begin
        inc = 1'b0;
        case (s2_rm)
            RM_RNE:  inc = s2_guard & (s2_stk | s2_sig[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s2_sign & nx;
            RM_RUP:  inc = ~s2_sign & nx;
            RM_RMM:  inc = s2_guard;
            default: inc = s2_guard & (s2_stk | s2_sig[0]);
        endcase
    end

    assign sum   = {1'b0, s2_sig} + 54'(inc);
    assign carry = sum[53];

    // A subnormal that rounds up to 2^52 becomes the smallest normal.
    always_comb begin
        exp_r = s2_exp + 13'(carry);
        if (s2_tiny && sum[52]) exp_r = 13'd1;
    end

    assign frac_r = carry ? 52'b0 : sum[51:0];
    assign ovf    = (exp_r >= 13'd2047);
    assign to_inf = (s2_rm == RM_RNE) || (s2_rm == RM_RMM) ||
                    ((s2_rm == RM_RUP) && !s2_sign) ||
                    ((s2_rm == RM_RDN) && s2_sign);

    always_comb begin
        res_c   = {s2_sign, exp_r[10:0], frac_r};
        flags_c = {3'b000, s2_tiny & nx, nx};
        if (s2_zero) begin
            res_c   = {s2_sign, 63'b0};
            flags_c = s2_zsticky ? 5'b00011 : 5'b00000;
        end else if (ovf) begin
            res_c   = to_inf ? {s2_sign, 11'h7FF, 52'b0} : {s2_sign, 11'h7FE, {52{1'b1}}};
            flags_c = 5'b00101;
        end
    end

    // ---------------- valid bits and output register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= 64'b0;
            out_flags  <= 5'b0;
        end else if (flush) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_result <= res_c;
                out_flags  <= flags_c;
            end
        end
    end

    // Datapath registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sign    <= in_sign;
            s1_rm      <= rm_c;
            s1_sticky  <= in_sticky;
            s1_zero    <= (in_mant == 64'b0);
            s1_exp     <= e1;
            s1_mant    <= norm_mant;

            s2_sign    <= s1_sign;
            s2_rm      <= s1_rm;
            s2_zero    <= s1_zero;
            s2_zsticky <= s1_sticky;
            s2_tiny    <= ~s2_normal;
            s2_exp     <= exp2;
            s2_sig     <= m2[63:11];
            s2_guard   <= m2[10];
            s2_stk     <= stk_pre | (|m2[9:0]);
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Bench for fp_norm_round: directed vector table, handshake/reset/flush
// sequences, and random traffic scored against an arithmetic reference model.
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [12:0] in_exp;
    logic [63:0] in_mant;
    logic        in_sticky;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_flags;

    always #5 clk = ~clk;

    fp_norm_round dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_sticky(in_sticky), .in_rm(in_rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    typedef struct {
        logic        sign;
        logic [12:0] exp;
        logic [63:0] mant;
        logic        sticky;
        logic [2:0]  rm;
        logic [63:0] res;
        logic [4:0]  flg;
    } vec_t;

    vec_t        vecs[$];
    logic [68:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic s, input int e, input logic [63:0] m,
                                input logic st, input logic [2:0] rm,
                                input logic [63:0] r, input logic [4:0] f);
        vec_t v;
        v.sign = s; v.exp = 13'(e); v.mant = m; v.sticky = st;
        v.rm = rm; v.res = r; v.flg = f;
        return v;
    endfunction

    // Reference: locate the ulp position in the raw magnitude, take the
    // integer quotient and remainder there, round, then build the encoding
    // by adding the rounded significand onto the exponent field.
    function automatic logic [68:0] ref_model(input logic sign, input logic [12:0] e13,
                                              input logic [63:0] m, input logic st,
                                              input logic [2:0] rm_in);
        int           p, be, k, e;
        logic [255:0] big, q, mask;
        logic         half, rest, inc, nx, uf, of;
        logic [2:0]   rm;
        logic [79:0]  pk;
        logic [63:0]  res;
        e  = int'(signed'(e13));
        rm = (rm_in > 3'd4) ? 3'd0 : rm_in;
        if (m == 64'b0) return {sign, 63'b0, st ? 5'b00011 : 5'b00000};
        p = 0;
        for (int i = 0; i < 64; i++) if (m[i]) p = i;
        be  = e - 63 + p;
        k   = (be >= 1) ? p - 52 : 12 - e;
        big = {192'b0, m} << 64;
        if (k + 64 > 250) begin
            q = '0; half = 1'b0; rest = 1'b1;
        end else begin
            q    = big >> (k + 64);
            half = big[k + 63];
            mask = (256'b1 << (k + 63)) - 256'b1;
            rest = (|(big & mask)) | st;
        end
        case (rm)
            3'd0:    inc = half & (rest | q[0]);
            3'd1:    inc = 1'b0;
            3'd2:    inc = sign & (half | rest);
            3'd3:    inc = ~sign & (half | rest);
            default: inc = half;
        endcase
        pk = ((be >= 1) ? 80'(be - 1) : 80'd0) << 52;
        pk = pk + 80'(q[52:0]) + 80'(inc);
        nx = half | rest;
        uf = (be < 1) & nx;
        of = 1'b0;
        if (pk >= (80'd2047 << 52)) begin
            of = 1'b1; nx = 1'b1;
            if ((rm == 3'd0) || (rm == 3'd4) || ((rm == 3'd3) && !sign) || ((rm == 3'd2) && sign))
                res = {sign, 11'h7FF, 52'b0};
            else
                res = {sign, 11'h7FE, {52{1'b1}}};
        end else begin
            res = {sign, pk[62:0]};
        end
        return {res, 2'b00, of, uf, nx};
    endfunction

    task automatic drive_op(input vec_t v);
        in_sign = v.sign; in_exp = v.exp; in_mant = v.mant;
        in_sticky = v.sticky; in_rm = v.rm;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   edges;
        v = vecs[i];
        @(negedge clk);
        drive_op(v); in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && edges < 10) begin
            @(posedge clk); edges++;
            @(negedge clk);
        end
        #1;
        check($sformatf("vec%0d latency", i), 69'(edges), 69'd3);
        check($sformatf("vec%0d result", i), 69'(out_result), 69'(v.res));
        check($sformatf("vec%0d flags", i), 69'(out_flags), 69'(v.flg));
    endtask

    task automatic handshake_test();
        vec_t        ops[4];
        logic [68:0] hs_exp[4];
        logic [68:0] first;
        logic        seen, held_ok;
        int          acc, nret, first_c, last_c;
        ops[0] = vecs[2]; ops[1] = vecs[3]; ops[2] = vecs[5]; ops[3] = vecs[9];
        for (int i = 0; i < 4; i++) hs_exp[i] = {ops[i].res, ops[i].flg};
        acc = 0; seen = 1'b0; held_ok = 1'b1; first = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            if (acc < 4) begin drive_op(ops[acc]); in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                if (!seen) begin first = {out_result, out_flags}; seen = 1'b1; end
                else if ({out_result, out_flags} !== first) held_ok = 1'b0;
            end
            if (in_valid && in_ready) acc++;
        end
        check("stall accepted", 69'(acc), 69'd3);
        check("stall in_ready", 69'(in_ready), 69'd0);
        check("stall out_valid", 69'(out_valid), 69'd1);
        check("stall first", first, hs_exp[0]);
        check("stall held", 69'(held_ok), 69'd1);
        nret = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 20 && nret < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (acc < 4) begin drive_op(ops[acc]); in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                check($sformatf("drain %0d", nret), {out_result, out_flags}, hs_exp[nret]);
                if (nret == 0) first_c = c;
                last_c = c;
                nret++;
            end
            if (in_valid && in_ready) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("drain count", 69'(nret), 69'd4);
        check("drain span", 69'(last_c - first_c), 69'd3);
    endtask

    task automatic reset_mid_test();
        int stale;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_op(vecs[i + 2]); in_valid = 1'b1; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midrst out_valid", 69'(out_valid), 69'd0);
        check("midrst result", 69'(out_result), 69'd0);
        check("midrst flags", 69'(out_flags), 69'd0);
        rst_n = 1'b1;
        #1;
        check("midrst in_ready", 69'(in_ready), 69'd1);
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("midrst stale", 69'(stale), 69'd0);
    endtask

    task automatic flush_test();
        int seen;
        @(negedge clk);
        drive_op(vecs[0]); in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; drive_op(vecs[3]);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush drops", 69'(seen), 69'd0);
        run_vec(4);
    endtask

    task automatic random_test(input int n);
        vec_t        pend;
        logic        have;
        int          issued, cyc, sel, e;
        logic [63:0] m;
        have = 1'b0; issued = 0; cyc = 0;
        pend = vecs[0];
        while ((issued < n || exp_q.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            in_valid  = (issued < n) && ($urandom_range(0, 9) < 7);
            if (in_valid && !have) begin
                pend.sign   = 1'($urandom_range(0, 1));
                pend.rm     = 3'($urandom_range(0, 7));
                pend.sticky = ($urandom_range(0, 3) == 0);
                m   = {$urandom, $urandom} >> $urandom_range(0, 63);
                sel = $urandom_range(0, 9);
                if (sel == 0) m = 64'b0;
                if (sel == 1) m = (m & ~64'h7FF) | 64'h400 | 64'h8000_0000_0000_0000;
                case ($urandom_range(0, 9))
                    0:       e = int'($urandom_range(0, 8191));
                    1:       e = -int'($urandom_range(0, 120));
                    2:       e = 1990 + int'($urandom_range(0, 120));
                    default: e = int'($urandom_range(0, 2100));
                endcase
                pend.mant = m;
                pend.exp  = 13'(e);
                have = 1'b1;
            end
            drive_op(pend);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rand spurious: got %h, expected no output", {out_result, out_flags});
                end else begin
                    check("rand out", {out_result, out_flags}, exp_q.pop_front());
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(pend.sign, pend.exp, pend.mant, pend.sticky, pend.rm));
                issued++;
                have = 1'b0;
            end
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("rand issued", 69'(issued), 69'(n));
        check("rand drained", 69'(exp_q.size()), 69'd0);
    endtask

    initial begin
        vecs.push_back(mk(0, 1023, 64'h8000000000000000, 0, 3'd0, 64'h3FF0000000000000, 5'h00));
        vecs.push_back(mk(0, 1086, 64'h0000000000000001, 0, 3'd0, 64'h3FF0000000000000, 5'h00));
        vecs.push_back(mk(0, 1023, 64'h8000000000000400, 0, 3'd0, 64'h3FF0000000000000, 5'h01));
        vecs.push_back(mk(0, 1023, 64'h8000000000000C00, 0, 3'd0, 64'h3FF0000000000002, 5'h01));
        vecs.push_back(mk(0, 1023, 64'h8000000000000400, 0, 3'd3, 64'h3FF0000000000001, 5'h01));
        vecs.push_back(mk(0, 2047, 64'h8000000000000000, 0, 3'd0, 64'h7FF0000000000000, 5'h05));
        vecs.push_back(mk(0, 2047, 64'h8000000000000000, 0, 3'd1, 64'h7FEFFFFFFFFFFFFF, 5'h05));
        vecs.push_back(mk(1, 2047, 64'h8000000000000000, 0, 3'd3, 64'hFFEFFFFFFFFFFFFF, 5'h05));
        vecs.push_back(mk(0, 0,    64'h8000000000000000, 0, 3'd0, 64'h0008000000000000, 5'h00));
        vecs.push_back(mk(0, -52,  64'h8000000000000000, 0, 3'd0, 64'h0000000000000000, 5'h03));
        vecs.push_back(mk(0, -52,  64'h8000000000000000, 0, 3'd3, 64'h0000000000000001, 5'h03));
        vecs.push_back(mk(1, 100,  64'h0000000000000000, 0, 3'd0, 64'h8000000000000000, 5'h00));
        vecs.push_back(mk(0, 100,  64'h0000000000000000, 1, 3'd3, 64'h0000000000000000, 5'h03));
        vecs.push_back(mk(0, 1023, 64'h8000000000000400, 0, 3'd4, 64'h3FF0000000000001, 5'h01));
        vecs.push_back(mk(0, 1023, 64'h8000000000000400, 0, 3'd7, 64'h3FF0000000000000, 5'h01));
        vecs.push_back(mk(0, 0,    64'hFFFFFFFFFFFFFFFF, 0, 3'd0, 64'h0010000000000000, 5'h03));
        vecs.push_back(mk(0, 1023, 64'hFFFFFFFFFFFFFFFF, 0, 3'd0, 64'h4000000000000000, 5'h01));
        vecs.push_back(mk(0, 2046, 64'hFFFFFFFFFFFFFFFF, 0, 3'd0, 64'h7FF0000000000000, 5'h05));
        vecs.push_back(mk(0, -4096, 64'h0000000000000001, 0, 3'd3, 64'h0000000000000001, 5'h03));
        vecs.push_back(mk(0, 1023, 64'h8000000000000400, 1, 3'd0, 64'h3FF0000000000001, 5'h01));

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_sign = 1'b0; in_exp = '0; in_mant = '0; in_sticky = 1'b0; in_rm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset out_valid", 69'(out_valid), 69'd0);
        check("reset result", 69'(out_result), 69'd0);
        check("reset flags", 69'(out_flags), 69'd0);
        check("reset in_ready", 69'(in_ready), 69'd1);

        for (int i = 0; i < vecs.size(); i++) run_vec(i);
        handshake_test();
        reset_mid_test();
        flush_test();
        random_test(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
